// File: rtl/key_event_decoder.sv
//------------------------------------------------------------------------------
// key_event_decoder
//   Consumer end of the key debounce path. Classifies each key gesture as a
//   single click, a double click or a long press and emits one registered
//   1-cycle event flag per gesture.
//
// Ports
//   sys_clk      in   system clock (all registers on posedge)
//   sys_rst_n    in   asynchronous, active-low reset
//   key_flag     in   debounced press pulse, 1 cycle wide
//   key_in       in   raw key level, 0 = pressed (release detection only)
//   single_flag  out  1-cycle pulse: single click recognised
//   double_flag  out  1-cycle pulse: double click recognised
//   long_flag    out  1-cycle pulse: long press recognised
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module key_event_decoder #(
    parameter logic [25:0] CNT_LONG = 26'd49_999_999,
    parameter logic [24:0] CNT_DBL  = 25'd14_999_999,
    parameter logic [19:0] CNT_REL  = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_flag,
    input  logic key_in,
    output logic single_flag,
    output logic double_flag,
    output logic long_flag
);

    localparam logic [25:0] LONG_LAST = CNT_LONG - 26'd1;
    localparam logic [24:0] DBL_LAST  = CNT_DBL  - 25'd1;
    localparam logic [19:0] REL_LAST  = CNT_REL  - 20'd1;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG_HOLD,
        WAIT2,
        PRESS2
    } state_e;

    state_e      state_q, state_d;
    logic [25:0] hold_cnt_q, hold_cnt_d;
    logic [24:0] gap_cnt_q,  gap_cnt_d;
    logic [19:0] rel_cnt_q,  rel_cnt_d;
    logic        single_q, single_d;
    logic        double_q, double_d;
    logic        long_q,   long_d;

    logic        rel_evt;
    logic        long_hit;
    logic        gap_hit;
    logic        rel_allowed;
    logic        enter_press;

    // Only the "key down" states care about a confirmed release.
    assign rel_allowed = (state_q == PRESS1) || (state_q == LONG_HOLD) ||
                         (state_q == PRESS2);
    assign rel_evt     = (rel_cnt_q == REL_LAST) && key_in && rel_allowed;
    assign long_hit    = (hold_cnt_q == LONG_LAST);
    assign gap_hit     = (gap_cnt_q == DBL_LAST);
    // A new press starts from a clean release count so a stale saturated
    // count cannot fire an immediate release.
    assign enter_press = key_flag && ((state_q == IDLE) || (state_q == WAIT2));

    // State and counter registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rel_cnt_q  <= '0;
            single_q   <= 1'b0;
            double_q   <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            single_q   <= single_d;
            double_q   <= double_d;
            long_q     <= long_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        if (!key_in) begin
            rel_cnt_d = '0;
        end else if (rel_cnt_q != REL_LAST) begin
            rel_cnt_d = rel_cnt_q + 20'd1;
        end else begin
            rel_cnt_d = rel_cnt_q;
        end
        if (enter_press) begin
            rel_cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (key_flag) begin
                    state_d    = PRESS1;
                    hold_cnt_d = '0;
                end
            end
            PRESS1: begin
                if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 26'd1;
                end
                // Long threshold beats a simultaneous release; the gesture
                // is then complete, so go straight back to IDLE.
                if (long_hit) begin
                    state_d = rel_evt ? IDLE : LONG_HOLD;
                end else if (rel_evt) begin
                    state_d   = WAIT2;
                    gap_cnt_d = '0;
                end
            end
            LONG_HOLD: begin
                if (rel_evt) begin
                    state_d = IDLE;
                end
            end
            WAIT2: begin
                gap_cnt_d = gap_cnt_q + 25'd1;
                // A second press on the expiry cycle still counts as double.
                if (key_flag) begin
                    state_d = PRESS2;
                end else if (gap_hit) begin
                    state_d = IDLE;
                end
            end
            PRESS2: begin
                if (rel_evt) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode, registered one cycle later
    always_comb begin
        single_d = (state_q == WAIT2)  && gap_hit && !key_flag;
        double_d = (state_q == PRESS2) && rel_evt;
        long_d   = (state_q == PRESS1) && long_hit;
    end

    assign single_flag = single_q;
    assign double_flag = double_q;
    assign long_flag   = long_q;

endmodule

// File: tb/tb_key_event_decoder.sv
`timescale 1ns/1ps

module tb_key_event_decoder;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_flag  = 1'b0;
    logic key_in    = 1'b1;
    logic single_flag, double_flag, long_flag;

    int checks = 0;
    int passes = 0;

    int cyc = 0;
    int n_single = 0, n_double = 0, n_long = 0, n_multi = 0;
    int last_single = -1, last_double = -1, last_long = -1;

    key_event_decoder #(
        .CNT_LONG(26'd100),
        .CNT_DBL (25'd50),
        .CNT_REL (20'd5)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_flag   (key_flag),
        .key_in     (key_in),
        .single_flag(single_flag),
        .double_flag(double_flag),
        .long_flag  (long_flag)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Pulse recorder: counts high cycles of each flag and when they occurred.
    always @(negedge sys_clk) begin
        if (single_flag === 1'b1) begin n_single++; last_single = cyc; end
        if (double_flag === 1'b1) begin n_double++; last_double = cyc; end
        if (long_flag   === 1'b1) begin n_long++;   last_long   = cyc; end
        if ((int'(single_flag) + int'(double_flag) + int'(long_flag)) > 1) n_multi++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Press at the current cycle, hold low for low_cycles, then release.
    // Returns the first cycle with key_in high.
    task automatic do_click(input int low_cycles, output int rise);
        key_flag = 1'b1;
        key_in   = 1'b0;
        tick(1);
        key_flag = 1'b0;
        tick(low_cycles - 1);
        key_in = 1'b1;
        rise   = cyc;
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        tick(3);
        checks++; if (single_flag !== 1'b0) $display("FAIL reset_single got=%b exp=0", single_flag); else passes++;
        checks++; if (double_flag !== 1'b0) $display("FAIL reset_double got=%b exp=0", double_flag); else passes++;
        checks++; if (long_flag   !== 1'b0) $display("FAIL reset_long got=%b exp=0", long_flag); else passes++;
        sys_rst_n = 1'b1;
        tick(10);
        checks++; if (n_single + n_double + n_long !== 0) $display("FAIL idle_quiet got=%0d exp=0", n_single + n_double + n_long); else passes++;
    endtask

    task automatic test_single;
        int r, s0, d0, l0;
        s0 = n_single; d0 = n_double; l0 = n_long;
        do_click(20, r);
        tick(70);
        checks++; if (n_single - s0 !== 1) $display("FAIL single_count got=%0d exp=1", n_single - s0); else passes++;
        checks++; if (last_single !== r + 55) $display("FAIL single_time got=%0d exp=%0d", last_single, r + 55); else passes++;
        checks++; if (n_double - d0 !== 0) $display("FAIL single_no_double got=%0d exp=0", n_double - d0); else passes++;
        checks++; if (n_long - l0 !== 0) $display("FAIL single_no_long got=%0d exp=0", n_long - l0); else passes++;
    endtask

    task automatic test_double;
        int r, r2, s0, d0, l0;
        s0 = n_single; d0 = n_double; l0 = n_long;
        do_click(20, r);
        tick(25);                     // WAIT2 began at r+5, now 20 cycles in
        key_in   = 1'b0;
        key_flag = 1'b1;
        tick(1);
        key_flag = 1'b0;
        tick(9);
        key_in = 1'b1;
        r2 = cyc;
        tick(80);
        checks++; if (n_double - d0 !== 1) $display("FAIL double_count got=%0d exp=1", n_double - d0); else passes++;
        checks++; if (last_double !== r2 + 5) $display("FAIL double_time got=%0d exp=%0d", last_double, r2 + 5); else passes++;
        checks++; if (n_single - s0 !== 0) $display("FAIL double_no_single got=%0d exp=0", n_single - s0); else passes++;
        checks++; if (n_long - l0 !== 0) $display("FAIL double_no_long got=%0d exp=0", n_long - l0); else passes++;
    endtask

    task automatic test_long;
        int t0, r, s0, d0, l0;
        s0 = n_single; d0 = n_double; l0 = n_long;
        t0 = cyc;
        do_click(150, r);
        tick(70);
        checks++; if (n_long - l0 !== 1) $display("FAIL long_count got=%0d exp=1", n_long - l0); else passes++;
        checks++; if (last_long !== t0 + 101) $display("FAIL long_time got=%0d exp=%0d", last_long, t0 + 101); else passes++;
        checks++; if (n_single - s0 !== 0) $display("FAIL long_no_single got=%0d exp=0", n_single - s0); else passes++;
        checks++; if (n_double - d0 !== 0) $display("FAIL long_no_double got=%0d exp=0", n_double - d0); else passes++;
        // Back in IDLE: a fresh click behaves as a normal single click.
        s0 = n_single;
        do_click(20, r);
        tick(70);
        checks++; if (n_single - s0 !== 1) $display("FAIL long_then_single_count got=%0d exp=1", n_single - s0); else passes++;
        checks++; if (last_single !== r + 55) $display("FAIL long_then_single_time got=%0d exp=%0d", last_single, r + 55); else passes++;
    endtask

    task automatic test_bounce;
        int t0, s0, d0, l0;
        s0 = n_single; d0 = n_double; l0 = n_long;
        t0 = cyc;
        key_flag = 1'b1;
        key_in   = 1'b0;
        tick(1);
        key_flag = 1'b0;
        tick(19);
        key_in = 1'b1;                // 3-cycle bounce, short of a release
        tick(3);
        key_in = 1'b0;
        tick(127);
        key_in = 1'b1;
        tick(70);
        checks++; if (n_long - l0 !== 1) $display("FAIL bounce_long_count got=%0d exp=1", n_long - l0); else passes++;
        checks++; if (last_long !== t0 + 101) $display("FAIL bounce_long_time got=%0d exp=%0d", last_long, t0 + 101); else passes++;
        checks++; if ((n_single - s0) + (n_double - d0) !== 0) $display("FAIL bounce_no_click got=%0d exp=0", (n_single - s0) + (n_double - d0)); else passes++;
    endtask

    task automatic test_tie;
        int r, r2, s0, d0, l0;
        s0 = n_single; d0 = n_double; l0 = n_long;
        do_click(20, r);
        tick(54);                     // gap_cnt == 49 in this cycle
        key_in   = 1'b0;
        key_flag = 1'b1;
        tick(1);
        key_flag = 1'b0;
        tick(119);                    // long hold in PRESS2 must not give long_flag
        key_in = 1'b1;
        r2 = cyc;
        tick(70);
        checks++; if (n_single - s0 !== 0) $display("FAIL tie_no_single got=%0d exp=0", n_single - s0); else passes++;
        checks++; if (n_double - d0 !== 1) $display("FAIL tie_double_count got=%0d exp=1", n_double - d0); else passes++;
        checks++; if (last_double !== r2 + 5) $display("FAIL tie_double_time got=%0d exp=%0d", last_double, r2 + 5); else passes++;
        checks++; if (n_long - l0 !== 0) $display("FAIL press2_no_long got=%0d exp=0", n_long - l0); else passes++;
    endtask

    task automatic test_reset_mid_wait2;
        int r, s0, d0, l0;
        s0 = n_single; d0 = n_double; l0 = n_long;
        do_click(20, r);
        tick(35);                     // gap_cnt == 30
        sys_rst_n = 1'b0;
        tick(2);
        checks++; if ({single_flag, double_flag, long_flag} !== 3'b000) $display("FAIL midrst_flags got=%b exp=000", {single_flag, double_flag, long_flag}); else passes++;
        sys_rst_n = 1'b1;
        tick(80);
        checks++; if (n_single - s0 !== 0) $display("FAIL midrst_no_single got=%0d exp=0", n_single - s0); else passes++;
        checks++; if ((n_double - d0) + (n_long - l0) !== 0) $display("FAIL midrst_no_other got=%0d exp=0", (n_double - d0) + (n_long - l0)); else passes++;
        s0 = n_single;
        do_click(10, r);
        tick(70);
        checks++; if (n_single - s0 !== 1) $display("FAIL midrst_restart_count got=%0d exp=1", n_single - s0); else passes++;
        checks++; if (last_single !== r + 55) $display("FAIL midrst_restart_time got=%0d exp=%0d", last_single, r + 55); else passes++;
    endtask

    initial begin
        test_reset();
        tick(5);
        test_single();
        tick(5);
        test_double();
        tick(5);
        test_long();
        tick(5);
        test_bounce();
        tick(5);
        test_tie();
        tick(5);
        test_reset_mid_wait2();
        tick(5);
        checks++; if (n_multi !== 0) $display("FAIL one_flag_per_cycle got=%0d exp=0", n_multi); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
